// File: rtl/fb_sprite_renderer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_sprite_renderer_if : frame request / framebuffer bundle           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fb_sprite_renderer_if #(
  parameter int FB_W   = 40,
  parameter int FB_H   = 30,
  parameter int NUM_CH = 3,
  parameter int CELL_W = 6,
  parameter int CELL_H = 5,
  parameter int XPOS_W = 6,
  parameter int YPOS_W = 5
);
  logic                              start;
  logic [NUM_CH-1:0]                 enable;
  logic [NUM_CH*CELL_W*CELL_H-1:0]   bitmaps;
  logic [NUM_CH*XPOS_W-1:0]          xpos;
  logic [NUM_CH*YPOS_W-1:0]          ypos;
  logic                              busy;
  logic                              done;
  logic [FB_W*FB_H-1:0]              framebuffer;

  modport master (
    output start, enable, bitmaps, xpos, ypos,
    input  busy, done, framebuffer
  );

  modport slave (
    input  start, enable, bitmaps, xpos, ypos,
    output busy, done, framebuffer
  );
endinterface
`default_nettype wire

// File: rtl/fb_sprite_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fb_sprite_renderer : draws NUM_CH clipped cell bitmaps into a back    |
// | buffer one row per cycle, then publishes the whole frame at once.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fb_sprite_renderer #(
  parameter int FB_W       = 40,
  parameter int FB_H       = 30,
  parameter int NUM_CH     = 3,
  parameter int CELL_W     = 6,
  parameter int CELL_H     = 5,
  parameter int XPOS_W     = 6,
  parameter int YPOS_W     = 5,
  parameter int Y_OFFSET   = 2,
  parameter int OVERLAP_OR = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  fb_sprite_renderer_if.slave  bus
);
  localparam int c_CELL_BITS = CELL_W * CELL_H;
  localparam int c_RI_W      = (FB_H   > 1) ? $clog2(FB_H)   : 1;
  localparam int c_CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int c_CR_W      = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int c_CJ_W      = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int c_TROW_W    = YPOS_W + 2;
  localparam logic [c_RI_W-1:0] c_LAST_ROW  = c_RI_W'(FB_H - 1);
  localparam logic [c_CR_W-1:0] c_LAST_CROW = c_CR_W'(CELL_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DRAW  = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [NUM_CH-1:0]               r_enable;
  logic [NUM_CH*c_CELL_BITS-1:0]   r_bitmaps;
  logic [NUM_CH*XPOS_W-1:0]        r_xpos;
  logic [NUM_CH*YPOS_W-1:0]        r_ypos;
  logic [c_RI_W-1:0]               r_row;
  logic [c_CH_W-1:0]               r_ch;
  logic [c_CR_W-1:0]               r_cell_row;
  logic [FB_W-1:0]                 r_back [FB_H];
  logic [FB_W*FB_H-1:0]            r_framebuffer;
  logic                            r_done;

  logic [c_CELL_BITS-1:0]          w_cur_bitmap;
  logic [XPOS_W-1:0]               w_cur_xpos;
  logic [YPOS_W-1:0]               w_cur_ypos;
  logic [CELL_W-1:0]               w_bm_row;
  logic [c_TROW_W-1:0]             w_trow;
  logic                            w_row_ok;
  logic [FB_W-1:0]                 w_seg_mask;
  logic [FB_W-1:0]                 w_seg_bits;
  logic [FB_W-1:0]                 w_old_row;
  logic [FB_W-1:0]                 w_new_row;
  logic                            w_has_first;
  logic                            w_has_next;
  logic [c_CH_W-1:0]               w_first_ch;
  logic [c_CH_W-1:0]               w_next_ch;

  // Current channel's latched fields, selected by mux rather than variable slicing.
  always_comb begin
    w_cur_bitmap = '0;
    w_cur_xpos   = '0;
    w_cur_ypos   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(r_ch) == c) begin
        w_cur_bitmap = r_bitmaps[c*c_CELL_BITS +: c_CELL_BITS];
        w_cur_xpos   = r_xpos[c*XPOS_W +: XPOS_W];
        w_cur_ypos   = r_ypos[c*YPOS_W +: YPOS_W];
      end
    end
  end

  always_comb begin
    w_bm_row = '0;
    for (int i = 0; i < CELL_H; i++) begin
      if (int'(r_cell_row) == i) begin
        w_bm_row = w_cur_bitmap[(CELL_H-1-i)*CELL_W +: CELL_W];
      end
    end
  end

  assign w_trow   = c_TROW_W'(w_cur_ypos) + c_TROW_W'(Y_OFFSET) + c_TROW_W'(r_cell_row);
  assign w_row_ok = (int'(w_trow) < FB_H);

  // Columns past the right edge simply have no framebuffer bit to land on.
  always_comb begin
    w_seg_mask = '0;
    w_seg_bits = '0;
    for (int k = 0; k < FB_W; k++) begin
      if ((k >= int'(w_cur_xpos)) && (k < int'(w_cur_xpos) + CELL_W)) begin
        w_seg_mask[k] = 1'b1;
        w_seg_bits[k] = w_bm_row[c_CJ_W'(k - int'(w_cur_xpos))];
      end
    end
  end

  assign w_old_row = w_row_ok ? r_back[c_RI_W'(w_trow)] : '0;
  assign w_new_row = (OVERLAP_OR != 0) ? (w_old_row | w_seg_bits)
                                       : ((w_old_row & ~w_seg_mask) | w_seg_bits);

  // Lowest enabled channel overall, and lowest enabled channel above r_ch.
  always_comb begin
    w_has_first = 1'b0;
    w_first_ch  = '0;
    w_has_next  = 1'b0;
    w_next_ch   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (r_enable[c]) begin
        w_has_first = 1'b1;
        w_first_ch  = c_CH_W'(c);
        if (c > int'(r_ch)) begin
          w_has_next = 1'b1;
          w_next_ch  = c_CH_W'(c);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_CLEAR;
      S_CLEAR: if (r_row == c_LAST_ROW) w_next_state = w_has_first ? S_DRAW : S_SWAP;
      S_DRAW:  if ((r_cell_row == c_LAST_CROW) && !w_has_next) w_next_state = S_SWAP;
      S_SWAP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_enable      <= '0;
      r_bitmaps     <= '0;
      r_xpos        <= '0;
      r_ypos        <= '0;
      r_row         <= '0;
      r_ch          <= '0;
      r_cell_row    <= '0;
      r_framebuffer <= '0;
      r_done        <= 1'b0;
      for (int r = 0; r < FB_H; r++) begin
        r_back[r] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_enable  <= bus.enable;
            r_bitmaps <= bus.bitmaps;
            r_xpos    <= bus.xpos;
            r_ypos    <= bus.ypos;
            r_row     <= '0;
          end
        end
        S_CLEAR: begin
          r_back[r_row] <= '0;
          r_row         <= r_row + c_RI_W'(1);
          if (r_row == c_LAST_ROW) begin
            r_ch       <= w_first_ch;
            r_cell_row <= '0;
          end
        end
        S_DRAW: begin
          // Off-bottom rows still burn their cycle so latency is position-independent.
          if (w_row_ok) begin
            r_back[c_RI_W'(w_trow)] <= w_new_row;
          end
          if (r_cell_row == c_LAST_CROW) begin
            r_cell_row <= '0;
            r_ch       <= w_next_ch;
          end else begin
            r_cell_row <= r_cell_row + c_CR_W'(1);
          end
        end
        S_SWAP: begin
          for (int r = 0; r < FB_H; r++) begin
            r_framebuffer[r*FB_W +: FB_W] <= r_back[r];
          end
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.framebuffer = r_framebuffer;
endmodule
`default_nettype wire
